// File: rtl/m16_pkg.sv
// Shared types and constants for the M16 frame sequencer slice.
package m16_pkg;

   localparam int M16_PTR_W           = 11;
   localparam int M16_GRP_W           = 5;
   localparam int M16_FRAME_WORDS_DEF = 2048;
   localparam int M16_GROUPS_DEF      = 32;
   localparam int M16_CLK_DIV_DEF     = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_FETCH = 3'd2,
      ST_LATCH = 3'd3,
      ST_ADV   = 3'd4
   } m16_state_e;

   // Frame index inside the group cycle; wraps by compare so GROUPS below 32 works.
   function automatic logic [M16_GRP_W-1:0] m16_grp_next(input logic [M16_GRP_W-1:0] grp,
                                                         input int groups);
      return (grp == M16_GRP_W'(groups - 1)) ? '0 : grp + M16_GRP_W'(1);
   endfunction

endpackage

// File: rtl/m16_frame_sequencer_if.sv
// Sequencer <-> filler bus. The sequencer owns the master modport.
// With M16_SEQ_EXT_TICK_EN defined the bus also carries the external word tick.
interface m16_frame_sequencer_if;
   import m16_pkg::*;

   logic                 enable;
`ifdef M16_SEQ_EXT_TICK_EN
   logic                 wordTick;
`endif
   logic                 bufGetWord;
   logic [M16_PTR_W-1:0] bufRdPointer;
   logic [M16_GRP_W-1:0] cntGrp;
   logic                 wordValid;
   logic                 frameStart;
   logic                 busy;
   logic                 overrun;

`ifdef M16_SEQ_EXT_TICK_EN
   modport master (input  enable, wordTick,
                   output bufGetWord, bufRdPointer, cntGrp, wordValid, frameStart, busy, overrun);
   modport slave  (output enable, wordTick,
                   input  bufGetWord, bufRdPointer, cntGrp, wordValid, frameStart, busy, overrun);
`else
   modport master (input  enable,
                   output bufGetWord, bufRdPointer, cntGrp, wordValid, frameStart, busy, overrun);
   modport slave  (output enable,
                   input  bufGetWord, bufRdPointer, cntGrp, wordValid, frameStart, busy, overrun);
`endif

endinterface

// File: rtl/m16_slot_timer.sv
// Word-slot tick source. Default: divider counting 0..CLK_DIV-1 while enabled,
// held at 0 otherwise, tick on the last count. With M16_SEQ_EXT_TICK_EN the
// external word tick is passed through instead and CLK_DIV is ignored.
module m16_slot_timer #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
`ifdef M16_SEQ_EXT_TICK_EN
   input  logic word_tick_i,
`endif
   output logic tick_o
);

`ifdef M16_SEQ_EXT_TICK_EN

   assign tick_o = en_i & word_tick_i;

`else

   localparam int              CNT_W    = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // next divider count: cleared while disabled, wraps after CLK_DIV-1
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // divider register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == CNT_LAST);

`endif

endmodule

// File: rtl/m16_frame_sequencer.sv
// M16 frame sequencer: paces word fetches for the filler, walks the word
// pointer through a frame and the frame counter through a group cycle.
// Optional build macro: M16_SEQ_EXT_TICK_EN (slot tick from bus wordTick).
module m16_frame_sequencer
   import m16_pkg::*;
#(
   parameter int CLK_DIV     = M16_CLK_DIV_DEF,
   parameter int FRAME_WORDS = M16_FRAME_WORDS_DEF,
   parameter int GROUPS      = M16_GROUPS_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   m16_frame_sequencer_if.master  bus
);

   localparam logic [M16_PTR_W-1:0] PTR_LAST = M16_PTR_W'(FRAME_WORDS - 1);

   m16_state_e           state_q, state_d;
   logic [M16_PTR_W-1:0] ptr_q, ptr_d;
   logic [M16_GRP_W-1:0] grp_q, grp_d;
   logic                 ovr_q, ovr_d;
   logic                 tick;
   logic                 busy;
   logic                 get_word;
   logic                 word_valid;
   logic                 frame_start;

   assign busy = (state_q != ST_IDLE);

   m16_slot_timer #(
      .CLK_DIV(CLK_DIV)
   ) u_slot_timer (
      .clk        (clk),
      .reset      (reset),
      .en_i       (busy),
`ifdef M16_SEQ_EXT_TICK_EN
      .word_tick_i(bus.wordTick),
`endif
      .tick_o     (tick)
   );

   // next state, pointer/group stepping, overrun tracking and strobes
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grp_d       = grp_q;
      ovr_d       = ovr_q;
      get_word    = 1'b0;
      word_valid  = 1'b0;
      frame_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ptr_d = '0;
            ovr_d = 1'b0;
            if (bus.enable) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (tick) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            get_word    = 1'b1;
            frame_start = (ptr_q == '0);
            if (tick) begin
               ovr_d = 1'b1;
            end
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            // filler registered dataWord on the FETCH edge
            word_valid = 1'b1;
            if (tick) begin
               ovr_d = 1'b1;
            end
            state_d = ST_ADV;
         end
         ST_ADV: begin
            if (tick) begin
               ovr_d = 1'b1;
            end
            if (ptr_q == PTR_LAST) begin
               // frame end is the only point where enable is honoured
               ptr_d   = '0;
               grp_d   = m16_grp_next(grp_q, GROUPS);
               state_d = bus.enable ? ST_WAIT : ST_IDLE;
            end else begin
               ptr_d   = ptr_q + M16_PTR_W'(1);
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grp_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grp_q   <= grp_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.bufGetWord   = get_word;
   assign bus.bufRdPointer = ptr_q;
   assign bus.cntGrp       = grp_q;
   assign bus.wordValid    = word_valid;
   assign bus.frameStart   = frame_start;
   assign bus.busy         = busy;
   assign bus.overrun      = ovr_q;

endmodule

// File: doc/m16_frame_sequencer.md
Name: m16_frame_sequencer

Overview:
Slot scheduler that drives the M16 word filler. It paces word fetches at a fixed word rate and issues one-cycle `bufGetWord` strobes with a stable `bufRdPointer`. It walks the pointer 0..2047 per frame and steps `cntGrp` 0..31 per frame. It flags `wordValid` when the filler's registered `dataWord` is ready for the serializer.

Parameters:
- CLK_DIV, default 16: clk cycles per word slot; legal range 4..65535.
- FRAME_WORDS, default 2048: words per frame; `bufRdPointer` wraps at FRAME_WORDS-1.
- GROUPS, default 32: frames per group cycle; `cntGrp` wraps at GROUPS-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request, level.
- bufGetWord  out  1  one-cycle fetch strobe to the filler.
- bufRdPointer  out  11  word index within the frame; stable from strobe until the next slot.
- cntGrp  out  5  frame index within the group cycle.
- wordValid  out  1  one-cycle pulse; filler `dataWord` is valid this cycle.
- frameStart  out  1  one-cycle pulse with the `bufGetWord` of pointer 0.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; a slot tick was missed.

Behaviour:
- Reset values: all outputs 0; state IDLE; divider 0; pointer 0; cntGrp 0.
- Reset is asynchronous and may occur mid-frame or mid-strobe. No partial pulse may survive it.
- Slot divider:
  - Counts 0..CLK_DIV-1 while busy and wraps.
  - Asserts `tick` internally when its count is CLK_DIV-1.
  - Held at 0 in IDLE.
- FSM states are IDLE, WAIT, FETCH, LATCH, ADV.
- IDLE:
  - Moves to WAIT when `enable`=1.
  - Pointer restarts at 0. `cntGrp` is preserved, so a restart continues the group sequence.
- WAIT: moves to FETCH on `tick`.
- FETCH:
  - `bufGetWord`=1 for exactly this cycle.
  - `frameStart`=1 in this cycle if pointer==0.
  - Always moves to LATCH.
- LATCH:
  - `wordValid`=1 for exactly this cycle. The filler registers `dataWord` on the FETCH edge, so latency is strobe+1 clk.
  - Moves to ADV.
- ADV:
  - If pointer==FRAME_WORDS-1: pointer becomes 0, and `cntGrp` becomes (cntGrp==GROUPS-1) ? 0 : cntGrp+1. Then go to IDLE if `enable`=0, else WAIT.
  - Otherwise pointer increments and the FSM returns to WAIT.
- `enable` dropping mid-frame takes effect only at frame end. The current frame always completes, and `busy` stays 1 until then.
- Pointer changes only in ADV, so `bufRdPointer` is constant for at least CLK_DIV-2 cycles around each strobe.
- Overrun:
  - A `tick` arriving in FETCH, LATCH or ADV sets `overrun`; that tick is dropped.
  - `overrun` is cleared only in IDLE or by reset.
  - With the internal divider and CLK_DIV≥4 it never fires.
- Widths:
  - Pointer is 11 bits and `cntGrp` is 5 bits.
  - Parameters smaller than full range wrap by compare, not by width overflow.

Optional Feature:
- Macro: M16_SEQ_EXT_TICK_EN.
- When defined:
  - Adds input `wordTick` (1 bit, one-cycle pulse from an external bit-rate timer).
  - Replaces the internal divider as the `tick` source; CLK_DIV is ignored.
  - Overrun detection is active, because external ticks may arrive closer than 4 clk apart.
- When undefined: no `wordTick` port; the internal divider is used.

Decomposition:
- Shared package m16_pkg holds:
  - state enum (IDLE, WAIT, FETCH, LATCH, ADV);
  - M16_PTR_W=11 and M16_GRP_W=5;
  - default FRAME_WORDS and GROUPS constants.
- One natural sub-module, m16_slot_timer: the divider/tick generator with an enable input and a `tick` output.
- With M16_SEQ_EXT_TICK_EN it reduces to a pass-through of `wordTick`.

Test Plan:
1. CLK_DIV=8, enable=1 from reset release:
   - First `bufGetWord` after 8 clk, then every 8 clk.
   - `wordValid` exactly 1 clk after each strobe.
   - `frameStart` with pointer=0.
2. Run a full frame: pointer sequence 0,1,…,2047,0. `cntGrp` goes 0→1 at wrap, with exactly 2048 strobes per frame.
3. Preload 31 frames (GROUPS=32): after frame 31 `cntGrp` returns to 0, and pointer 594 with cntGrp=0 occurs once per 32 frames.
4. Drop enable at pointer 100:
   - Strobes continue to pointer 2047.
   - Then `busy`=0, pointer=0, `cntGrp` incremented.
   - Re-enable resumes at the same `cntGrp`.
5. Assert reset during LATCH at pointer 4:
   - All outputs 0 immediately; no `wordValid` pulse follows.
   - After release with enable=1, the first strobe has pointer=0.
6. M16_SEQ_EXT_TICK_EN, `wordTick` pulses 2 clk apart:
   - Every second tick is dropped and `overrun`=1, held until IDLE.
   - At 10-clk spacing, `overrun` stays 0.
